// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for the shared line-wide memory port
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int LINE_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_res_ready,
    output logic [LINE_W-1:0] i_res_data,
    input  logic              d_req_valid,
    input  logic              d_req_rw,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [LINE_W-1:0] d_req_data,
    output logic              d_res_ready,
    output logic [LINE_W-1:0] d_res_data,
    output logic              mem_req_valid,
    output logic              mem_req_rw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_req_data,
    input  logic              mem_res_ready,
    input  logic [LINE_W-1:0] mem_res_data,
    output logic [1:0]        owner,
    output logic              protocol_err
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    state_t     state_next;
    logic [3:0] starve_cnt;
    logic       grant_i;
    logic       grant_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // D wins by default; I wins when D is absent or I has waited out STARVE_LIMIT D grants.
    always_comb begin
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (i_req_valid && (!d_req_valid || starve_cnt == LIMIT)) begin
                    grant_i    = 1'b1;
                    state_next = BUSY_I;
                end else if (d_req_valid) begin
                    grant_d    = 1'b1;
                    state_next = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_res_ready) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt    <= '0;
            mem_req_valid <= 1'b0;
            mem_req_rw    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
            i_res_ready   <= 1'b0;
            i_res_data    <= '0;
            d_res_ready   <= 1'b0;
            d_res_data    <= '0;
            owner         <= 2'b00;
            protocol_err  <= 1'b0;
        end else begin
            if (grant_i) begin
                mem_req_valid <= 1'b1;
                mem_req_rw    <= 1'b0;
                mem_req_addr  <= i_req_addr;
                mem_req_data  <= '0;
                owner         <= 2'b01;
                starve_cnt    <= '0;
            end

            if (grant_d) begin
                mem_req_valid <= 1'b1;
                mem_req_rw    <= d_req_rw;
                mem_req_addr  <= d_req_addr;
                mem_req_data  <= d_req_data;
                owner         <= 2'b10;
                if (!i_req_valid) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != LIMIT) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end

            if (state == BUSY_I && mem_res_ready) begin
                mem_req_valid <= 1'b0;
                i_res_ready   <= 1'b1;
                i_res_data    <= mem_res_data;
            end

            if (state == BUSY_D && mem_res_ready) begin
                mem_req_valid <= 1'b0;
                d_res_ready   <= 1'b1;
                d_res_data    <= mem_res_data;
            end

            if (state == DONE) begin
                owner       <= 2'b00;
                i_res_ready <= 1'b0;
                i_res_data  <= '0;
                d_res_ready <= 1'b0;
                d_res_data  <= '0;
            end

            // A completion with nothing outstanding means memory and arbiter disagree.
            if (mem_res_ready && (state == IDLE || state == DONE)) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              i_req_valid = 1'b0;
    logic [ADDR_W-1:0] i_req_addr = '0;
    logic              i_res_ready;
    logic [LINE_W-1:0] i_res_data;
    logic              d_req_valid = 1'b0;
    logic              d_req_rw = 1'b0;
    logic [ADDR_W-1:0] d_req_addr = '0;
    logic [LINE_W-1:0] d_req_data = '0;
    logic              d_res_ready;
    logic [LINE_W-1:0] d_res_data;
    logic              mem_req_valid;
    logic              mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [LINE_W-1:0] mem_req_data;
    logic              mem_res_ready = 1'b0;
    logic [LINE_W-1:0] mem_res_data = '0;
    logic [1:0]        owner;
    logic              protocol_err;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_LIMIT(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .i_req_valid   (i_req_valid),
        .i_req_addr    (i_req_addr),
        .i_res_ready   (i_res_ready),
        .i_res_data    (i_res_data),
        .d_req_valid   (d_req_valid),
        .d_req_rw      (d_req_rw),
        .d_req_addr    (d_req_addr),
        .d_req_data    (d_req_data),
        .d_res_ready   (d_res_ready),
        .d_res_data    (d_res_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_rw    (mem_req_rw),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_res_ready (mem_res_ready),
        .mem_res_data  (mem_res_data),
        .owner         (owner),
        .protocol_err  (protocol_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_grant(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (mem_req_valid) seen = 1'b1;
        end
        check(tag, {127'd0, seen}, 128'd1);
    endtask

    // Completion pulse lands on the lat-th edge from now.
    task automatic serve(input int lat, input logic [LINE_W-1:0] rdata);
        for (int k = 1; k < lat; k++) step();
        mem_res_ready = 1'b1;
        mem_res_data  = rdata;
        step();
        mem_res_ready = 1'b0;
        mem_res_data  = '0;
    endtask

    localparam logic [LINE_W-1:0] PAT_A5  = {16{8'hA5}};
    localparam logic [LINE_W-1:0] I_LINE  = 128'hDEADBEEF_00000000_00000000_00000001;
    localparam logic [LINE_W-1:0] D_LINE  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

    initial begin
        // 1: reset state and a single D write-back
        #12;
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_mem_req_addr", mem_req_addr, 0);
        check("rst_owner", owner, 0);
        check("rst_res_ready", {i_res_ready, d_res_ready}, 0);
        check("rst_protocol_err", protocol_err, 0);
        step();
        reset = 1'b1;
        step();
        d_req_valid = 1'b1;
        d_req_rw    = 1'b1;
        d_req_addr  = 32'h100;
        d_req_data  = PAT_A5;
        wait_grant("t1_grant");
        check("t1_rw", mem_req_rw, 1);
        check("t1_addr", mem_req_addr, 32'h100);
        check("t1_data", mem_req_data, PAT_A5);
        check("t1_owner", owner, 2'b10);
        serve(3, D_LINE);
        check("t1_d_res_ready", d_res_ready, 1);
        check("t1_i_res_ready", i_res_ready, 0);
        check("t1_mem_valid_drop", mem_req_valid, 0);
        d_req_valid = 1'b0;
        step();
        check("t1_d_res_pulse_end", d_res_ready, 0);
        check("t1_owner_clear", owner, 0);
        check("t1_d_res_data_clear", d_res_data, 0);

        // 2: I refill
        i_req_valid = 1'b1;
        i_req_addr  = 32'h2000;
        wait_grant("t2_grant");
        check("t2_owner", owner, 2'b01);
        check("t2_addr", mem_req_addr, 32'h2000);
        check("t2_rw", mem_req_rw, 0);
        check("t2_data", mem_req_data, 0);
        serve(2, I_LINE);
        check("t2_i_res_ready", i_res_ready, 1);
        check("t2_i_res_data", i_res_data, I_LINE);
        check("t2_d_res_ready", d_res_ready, 0);
        i_req_valid = 1'b0;
        step();
        check("t2_i_res_pulse_end", i_res_ready, 0);

        // 3: starvation bound, both requesting from the same cycle
        d_req_rw    = 1'b0;
        d_req_addr  = 32'h200;
        d_req_data  = '0;
        i_req_addr  = 32'h2040;
        i_req_valid = 1'b1;
        d_req_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic [1:0] exp_owner;
            logic [3:0] exp_cnt;
            exp_owner = (k == 4) ? 2'b01 : 2'b10;
            exp_cnt   = (k < 4) ? 4'(k + 1) : 4'd0;
            wait_grant($sformatf("t3_grant%0d", k));
            check($sformatf("t3_owner%0d", k), owner, exp_owner);
            check($sformatf("t3_starve%0d", k), dut.starve_cnt, exp_cnt);
            serve(1, 128'(k + 16));
            if (exp_owner == 2'b01) begin
                check($sformatf("t3_i_res%0d", k), i_res_ready, 1);
                check($sformatf("t3_i_data%0d", k), i_res_data, 128'(k + 16));
                i_req_valid = 1'b0;
            end else begin
                check($sformatf("t3_d_res%0d", k), d_res_ready, 1);
            end
        end
        d_req_valid = 1'b0;
        step();

        // 4: requester fields not re-sampled while busy
        d_req_rw    = 1'b1;
        d_req_addr  = 32'h100;
        d_req_data  = PAT_A5;
        d_req_valid = 1'b1;
        wait_grant("t4_grant");
        d_req_addr = 32'h140;
        d_req_rw   = 1'b0;
        step();
        check("t4_addr_held", mem_req_addr, 32'h100);
        check("t4_rw_held", mem_req_rw, 1);
        serve(2, D_LINE);
        check("t4_d_res_ready", d_res_ready, 1);
        d_req_valid = 1'b0;
        step();

        // 5: reset during BUSY_I, then a stray completion
        i_req_valid = 1'b1;
        i_req_addr  = 32'h3000;
        wait_grant("t5_grant");
        check("t5_owner_i", owner, 2'b01);
        step();
        reset = 1'b0;
        #1;
        check("t5_rst_owner", owner, 0);
        check("t5_rst_mem_valid", mem_req_valid, 0);
        i_req_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        mem_res_ready = 1'b1;
        step();
        mem_res_ready = 1'b0;
        check("t5_protocol_err", protocol_err, 1);
        check("t5_no_i_res", i_res_ready, 0);
        check("t5_owner_none", owner, 0);
        d_req_rw    = 1'b0;
        d_req_addr  = 32'h180;
        d_req_valid = 1'b1;
        wait_grant("t5_d_grant");
        check("t5_d_owner", owner, 2'b10);
        check("t5_d_addr", mem_req_addr, 32'h180);
        serve(1, D_LINE);
        check("t5_d_res_ready", d_res_ready, 1);
        check("t5_d_res_data", d_res_data, D_LINE);
        d_req_valid = 1'b0;
        step();
        check("t5_err_sticky", protocol_err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single line-wide data-memory port between two line-refill requesters. The requesters are the instruction-cache refill path (read-only) and the data-cache FSM (read/write-back).
- Sits between both cache controllers and the memory model.
- Grants one whole transaction at a time, registers the request toward memory and routes the response back to the owner.
- Data side has default priority; a starvation counter bounds instruction-side wait.

Parameters:
ADDR_W, 32, request address width
LINE_W, 128, cache line / memory transfer width
STARVE_LIMIT, 4, consecutive D grants while I waits before I is forced to win; legal range 1..15

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
i_req_valid  in  1  I-refill request; held stable until i_res_ready seen
i_req_addr  in  ADDR_W  I-refill line address
i_res_ready  out  1  one-cycle pulse: I transaction complete
i_res_data  out  LINE_W  line returned to I side; valid while i_res_ready
d_req_valid  in  1  D request; held stable until d_res_ready seen
d_req_rw  in  1  1 = write-back, 0 = refill
d_req_addr  in  ADDR_W  D line address
d_req_data  in  LINE_W  write-back line
d_res_ready  out  1  one-cycle pulse: D transaction complete
d_res_data  out  LINE_W  line returned to D side; valid while d_res_ready
mem_req_valid  out  1  request to memory
mem_req_rw  out  1  to memory
mem_req_addr  out  ADDR_W  to memory
mem_req_data  out  LINE_W  to memory
mem_res_ready  in  1  memory completion pulse
mem_res_data  in  LINE_W  memory read line
owner  out  2  00 none, 01 I, 10 D (current grant)
protocol_err  out  1  sticky: mem_res_ready seen with no grant outstanding

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, starve_cnt=0.
  - All outputs 0: mem_req_*, *_res_ready, *_res_data, owner, protocol_err.
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE arbitration, evaluated every IDLE cycle:
  - winner = I if i_req_valid && (!d_req_valid || starve_cnt==STARVE_LIMIT); else D if d_req_valid; else stay in IDLE.
- Grant at edge N:
  - Capture the winner's fields into the mem_req_* registers; mem_req_valid=1 from cycle N+1.
  - I grant always drives mem_req_rw=0 and mem_req_data=0.
  - owner updates at the same edge.
- BUSY_x:
  - mem_req_* held constant until mem_res_ready is sampled high.
  - Requester inputs are not re-sampled after the grant.
- Edge where mem_res_ready=1 in BUSY_x:
  - mem_req_valid→0 and state→DONE.
  - x_res_ready←1 for exactly one cycle.
  - x_res_data←mem_res_data, registered for both read and write; write response data is don't-care.
  - Other side's res signals stay 0.
- DONE: no arbitration, which gives the requester one cycle to drop valid. Next edge → IDLE and owner←00; res_ready and res_data clear to 0.
- Minimum back-to-back spacing is 3 cycles: grant, memory latency ≥1, DONE, IDLE.
- starve_cnt:
  - On a D grant while i_req_valid=1: increment, saturating at STARVE_LIMIT.
  - On any I grant: clear to 0.
  - On a D grant while i_req_valid=0: clear to 0.
- mem_res_ready in IDLE or DONE: ignored for routing, and sets protocol_err (cleared only by reset).
- Reset asserted mid-transaction: the transaction is abandoned and no res_ready is produced. The memory's late response is then handled by the IDLE rule, which sets protocol_err, so the bench must quiesce memory across reset.
- Requester dropping valid before its response: unsupported; the arbiter completes the transaction and still pulses res_ready.

Test Plan:
1. Reset → all outputs 0; only d_req_valid=1, rw=1, addr=0x100, data=0xA5..A5 → cycle after grant edge: mem_req_valid=1, rw=1, addr 0x100, owner=10; memory ready after 3 cycles → d_res_ready pulses exactly 1 cycle, i_res_ready stays 0.
2. I refill addr 0x2000, memory returns 0xDEADBEEF_..._0001 → i_res_data equals it during the i_res_ready pulse; mem_req_rw=0 and mem_req_data=0 throughout.
3. i_req_valid and d_req_valid raised in the same cycle, STARVE_LIMIT=4, D re-requests every time → D granted 4 times, 5th grant goes to I, starve_cnt reads 0 afterwards, following grant is D.
4. Change d_req_addr from 0x100 to 0x140 during BUSY_D → mem_req_addr stays 0x100 until completion.
5. Assert reset during BUSY_I, then pulse mem_res_ready after release → no i_res_ready, owner=00, protocol_err=1; a new D request is then served normally.
